spi_rx_target: RTL and testbench

//  Memory-mapped SPI receiver (target side), the counterpart of the SPI0 transmitter.
//  - Samples external sclk_in/mosi_in framed by ss_n_in, MSB first, 32-bit words.
//  - Words go to a holding register (or FIFO), read by the processor over the peripheral bus.
//  - The interrupt request flags data-ready.

---
 rtl/spi_pkg.sv | 36 +++
 rtl/spi_rx_fifo.sv | 59 +++++
 rtl/spi_rx_target.sv | 236 +++++++++++++++++++++++
 tb/tb_spi_rx_target.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// SPI target receiver shared definitions: register addresses, bit indices, FSM and cfg types.
// Latency: n/a (package only).
// Backpressure: n/a.
package spi_pkg;

  // Peripheral register map
  localparam logic [1:0] ADDR_STATUS = 2'b00;
  localparam logic [1:0] ADDR_DATA   = 2'b01;
  localparam logic [1:0] ADDR_CFG    = 2'b10;
  localparam logic [1:0] ADDR_RSVD   = 2'b11;

  // Status read-back bit positions
  localparam int ST_RX_VALID  = 0;
  localparam int ST_BUSY      = 1;
  localparam int ST_OVERRUN   = 2;
  localparam int ST_FRAME_ERR = 3;
  localparam int ST_LEVEL_LSB = 4;

  // Status write-1-to-clear bit positions (not the same as the read positions)
  localparam int W1C_OVERRUN   = 1;
  localparam int W1C_FRAME_ERR = 2;

  // Config register bit positions
  localparam int CFG_ENABLE = 0;
  localparam int CFG_EDGE   = 1;
  localparam int CFG_IRQ_EN = 2;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} spi_rx_state_t;

  typedef struct packed {
    logic irq_en;
    logic edge_sel;   // 0: sample on rising sclk, 1: sample on falling sclk
    logic enable;
  } spi_rx_cfg_t;

endpackage

// File: rtl/spi_rx_fifo.sv
// Synchronous RX word FIFO with occupancy level; push when full is dropped unless a pop happens the same cycle.
// Latency: written word visible at dout one cycle after push; dout is the head entry combinationally.
// Backpressure: none upstream; caller observes full and decides (overrun), pop on empty is ignored.
// Ports: clk/rst (sync, active-high), push/din, pop/dout, full, empty, level (0..DEPTH).
module spi_rx_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       level
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign level = count;
  assign dout  = mem[rd_ptr];

  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_rx_target.sv
// Memory-mapped SPI target receiver: synchronizes sclk/ss_n/mosi, shifts MSB-first words, holds them for bus reads.
// Latency: pin edge to shift is SYNC_STAGES+1 clk; register reads are combinational, pop takes effect next cycle.
// Backpressure: none toward SPI; a word arriving with no room is dropped and flags overrun.
// Ports: clk, rst (sync active-high); bus data_in/addr/we/rd_en/cs_n/data_out (z when cs_n=1);
//        SPI pins sclk_in/ss_n_in/mosi_in (async); irq = registered rx_valid & irq_en.
// Build option: define SPI_RX_FIFO_EN to replace the holding register with a FIFO_DEPTH-entry FIFO.
module spi_rx_target
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        addr,
  input  logic              we,
  input  logic              rd_en,
  input  logic              cs_n,
  output logic [DATA_W-1:0] data_out,
  input  logic              sclk_in,
  input  logic              ss_n_in,
  input  logic              mosi_in,
  output logic              irq
);

  localparam int CNT_W = $clog2(DATA_W);

  // ---------------------------------------------------------------- pin sync
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_prev;
  logic                   ss_prev;
  logic                   sclk_s;
  logic                   ss_s;
  logic                   mosi_s;

  // ss_n resets high so that leaving reset never looks like a frame start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      ss_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n_in};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
      sclk_prev <= sclk_s;
      ss_prev   <= ss_s;
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------- bus decode
  spi_rx_cfg_t cfg;
  logic        wr_strobe;
  logic        pop_req;

  assign wr_strobe = we && !cs_n;
  assign pop_req   = rd_en && !cs_n && (addr == ADDR_DATA);

  // ---------------------------------------------------------------- shifter FSM
  spi_rx_state_t     state;
  logic [DATA_W-1:0] shift_reg;
  logic [CNT_W-1:0]  bit_cnt;
  logic              sclk_rise;
  logic              sclk_fall;
  logic              sample_edge;
  logic              ss_fall;
  logic              in_frame;
  logic              word_push;
  logic [DATA_W-1:0] word_dat;
  logic              frame_err;
  logic              frame_err_set;
  logic              busy;

  assign sclk_rise   = sclk_s && !sclk_prev;
  assign sclk_fall   = !sclk_s && sclk_prev;
  assign sample_edge = cfg.edge_sel ? sclk_fall : sclk_rise;
  assign ss_fall     = !ss_s && ss_prev;

  // Active shifting: enabled, still selected; disable and ss_n release take priority over a sample.
  assign in_frame      = (state == SHIFT) && cfg.enable && !ss_s;
  assign word_push     = in_frame && sample_edge && (bit_cnt == CNT_W'(DATA_W-1));
  assign word_dat      = {shift_reg[DATA_W-2:0], mosi_s};
  assign frame_err_set = (state == SHIFT) && cfg.enable && ss_s && (bit_cnt != '0);
  assign busy          = (state == SHIFT) && (bit_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ss_fall && cfg.enable) begin
            state   <= SHIFT;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (!cfg.enable || ss_s) begin
            // Partial word is abandoned; the error flag is handled separately.
            state   <= IDLE;
            bit_cnt <= '0;
          end else if (sample_edge) begin
            shift_reg <= word_dat;
            bit_cnt   <= word_push ? '0 : bit_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX storage
  logic              rx_valid;
  logic [DATA_W-1:0] rx_word;
  logic [3:0]        level4;
  logic              overrun;
  logic              overrun_set;

`ifdef SPI_RX_FIFO_EN
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level;

  spi_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (word_push),
    .din   (word_dat),
    .pop   (pop_req),
    .dout  (rx_word),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign rx_valid    = !fifo_empty;
  assign level4      = 4'(fifo_level);
  // A same-cycle pop makes room, so only an un-popped push into a full FIFO is lost.
  assign overrun_set = word_push && fifo_full && !pop_req;
`else
  logic              hold_vld;
  logic [DATA_W-1:0] hold_dat;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld <= 1'b0;
      hold_dat <= '0;
    end else if (word_push && (!hold_vld || pop_req)) begin
      hold_vld <= 1'b1;
      hold_dat <= word_dat;
    end else if (pop_req) begin
      hold_vld <= 1'b0;
    end
  end

  assign rx_valid    = hold_vld;
  assign rx_word     = hold_dat;
  assign level4      = {3'b000, hold_vld};
  assign overrun_set = word_push && hold_vld && !pop_req;
`endif

  // ---------------------------------------------------------------- flags / cfg / irq
  // A fresh error event in the same cycle as its W1C keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg       <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (wr_strobe && addr == ADDR_CFG) begin
        cfg.enable   <= data_in[CFG_ENABLE];
        cfg.edge_sel <= data_in[CFG_EDGE];
        cfg.irq_en   <= data_in[CFG_IRQ_EN];
      end

      if (overrun_set)
        overrun <= 1'b1;
      else if (wr_strobe && addr == ADDR_STATUS && data_in[W1C_OVERRUN])
        overrun <= 1'b0;

      if (frame_err_set)
        frame_err <= 1'b1;
      else if (wr_strobe && addr == ADDR_STATUS && data_in[W1C_FRAME_ERR])
        frame_err <= 1'b0;

      irq <= rx_valid && cfg.irq_en;
    end
  end

  // ---------------------------------------------------------------- read mux
  logic [DATA_W-1:0] status_word;
  logic [DATA_W-1:0] rd_data;

  always_comb begin
    status_word                       = '0;
    status_word[ST_RX_VALID]          = rx_valid;
    status_word[ST_BUSY]              = busy;
    status_word[ST_OVERRUN]           = overrun;
    status_word[ST_FRAME_ERR]         = frame_err;
    status_word[ST_LEVEL_LSB +: 4]    = level4;
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      ADDR_STATUS: rd_data = status_word;
      ADDR_DATA:   rd_data = rx_valid ? rx_word : '0;
      ADDR_CFG:    rd_data = DATA_W'(cfg);
      ADDR_RSVD:   rd_data = '0;
      default:     rd_data = '0;
    endcase
  end

  assign data_out = cs_n ? {DATA_W{1'bz}} : rd_data;

  // Upper write-data bits carry no register fields.
  logic unused_bits;
  assign unused_bits = ^{data_in[DATA_W-1:3], FIFO_DEPTH[0]};

endmodule

// File: tb/tb_spi_rx_target.sv
// Self-checking bench for spi_rx_target: random words over a bit-banged SPI master, scored against a word-queue model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_spi_rx_target;

  localparam int SYNC = 2;
`ifdef SPI_RX_FIFO_EN
  localparam int CAP     = 4;
  localparam bit FIFO_ON = 1'b1;
`else
  localparam int CAP     = 1;
  localparam bit FIFO_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic [1:0]  addr;
  logic        we;
  logic        rd_en;
  logic        cs_n;
  wire  [31:0] data_out;
  logic        sclk_in;
  logic        ss_n_in;
  logic        mosi_in;
  wire         irq;

  int errors = 0;
  int checks = 0;

  // Reference model: words the receiver should be holding, plus sticky flags.
  logic [31:0] mq[$];
  bit          m_ov;
  bit          m_fe;

  spi_rx_target #(.SYNC_STAGES(SYNC), .DATA_W(32), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .addr     (addr),
    .we       (we),
    .rd_en    (rd_en),
    .cs_n     (cs_n),
    .data_out (data_out),
    .sclk_in  (sclk_in),
    .ss_n_in  (ss_n_in),
    .mosi_in  (mosi_in),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_status();
    int         lvl;
    logic [3:0] l4;
    logic       vld;
    vld = (mq.size() != 0);
    lvl = FIFO_ON ? mq.size() : int'(vld);
    l4  = lvl[3:0];
    return {24'b0, l4, m_fe, m_ov, 1'b0, vld};
  endfunction

  function automatic void model_frame(input logic [31:0] w);
    if (mq.size() < CAP) mq.push_back(w);
    else m_ov = 1'b1;
  endfunction

  function automatic logic [31:0] model_pop();
    if (mq.size() == 0) return 32'h0;
    return mq.pop_front();
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    cs_n = 1'b0; we = 1'b1; addr = a; data_in = d;
    tick(1);
    we = 1'b0; cs_n = 1'b1; data_in = 32'h0;
  endtask

  task automatic bus_read(input logic [1:0] a, input bit pop, output logic [31:0] d);
    cs_n = 1'b0; addr = a; rd_en = pop;
    #2;
    d = data_out;
    @(posedge clk);
    #1;
    rd_en = 1'b0; cs_n = 1'b1;
  endtask

  // mode 0: data set while sclk low, sampled on rise. mode 1: data launched on rise, sampled on fall.
  task automatic send_bits(input logic [31:0] w, input int n, input bit mode);
    for (int i = 0; i < n; i++) begin
      if (!mode) begin
        mosi_in = w[31-i]; tick(2); sclk_in = 1'b1; tick(2); sclk_in = 1'b0;
      end else begin
        sclk_in = 1'b1; mosi_in = w[31-i]; tick(2); sclk_in = 1'b0; tick(2);
      end
    end
  endtask

  task automatic ss_low();
    ss_n_in = 1'b0; tick(4);
  endtask

  task automatic ss_high();
    tick(4); ss_n_in = 1'b1; tick(SYNC + 6);
  endtask

  task automatic send_word(input logic [31:0] w, input bit mode);
    ss_low();
    send_bits(w, 32, mode);
    ss_high();
    model_frame(w);
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    logic [31:0] d;
    bus_read(2'b00, 1'b0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status: got %h required %h", d, 32'h0); end
    bus_read(2'b10, 1'b0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_cfg: got %h required %h", d, 32'h0); end
    bus_read(2'b01, 1'b0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_data: got %h required %h", d, 32'h0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b required 0", irq); end
  endtask

  task automatic test_rising();
    logic [31:0] d, e, w;
    bus_write(2'b10, 32'h1);
    for (int k = 0; k < 4; k++) begin
      w = (k == 0) ? 32'hA5C3_0F96 : $urandom;
      send_word(w, 1'b0);
      bus_read(2'b00, 1'b0, d); e = exp_status();
      checks++; if (d !== e) begin errors++; $display("FAIL rise_status_full: got %h required %h", d, e); end
      bus_read(2'b01, 1'b1, d); e = model_pop();
      checks++; if (d !== e) begin errors++; $display("FAIL rise_data: got %h required %h", d, e); end
      bus_read(2'b00, 1'b0, d); e = exp_status();
      checks++; if (d !== e) begin errors++; $display("FAIL rise_status_empty: got %h required %h", d, e); end
    end
  endtask

  task automatic test_falling();
    logic [31:0] d, e, w;
    bus_write(2'b10, 32'h3);
    bus_read(2'b10, 1'b0, d);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL fall_cfg: got %h required %h", d, 32'h3); end
    for (int k = 0; k < 3; k++) begin
      w = (k == 0) ? 32'h8000_0001 : $urandom;
      send_word(w, 1'b1);
      bus_read(2'b01, 1'b1, d); e = model_pop();
      checks++; if (d !== e) begin errors++; $display("FAIL fall_data: got %h required %h", d, e); end
    end
  endtask

  task automatic test_overrun();
    logic [31:0] d, e;
    bus_write(2'b10, 32'h1);
    send_word($urandom, 1'b0);
    send_word($urandom, 1'b0);
    bus_read(2'b00, 1'b0, d); e = exp_status();
    checks++; if (d !== e) begin errors++; $display("FAIL ovr_status: got %h required %h", d, e); end
    bus_write(2'b00, 32'h2); m_ov = 1'b0;
    bus_read(2'b00, 1'b0, d); e = exp_status();
    checks++; if (d !== e) begin errors++; $display("FAIL ovr_w1c: got %h required %h", d, e); end
    for (int k = 0; k < 3; k++) begin
      bus_read(2'b01, 1'b1, d); e = model_pop();
      checks++; if (d !== e) begin errors++; $display("FAIL ovr_data: got %h required %h", d, e); end
    end
  endtask

  task automatic test_frame_err();
    logic [31:0] d, e;
    bus_write(2'b10, 32'h1);
    ss_low();
    send_bits($urandom, 12, 1'b0);
    ss_high(); m_fe = 1'b1;
    bus_read(2'b00, 1'b0, d); e = exp_status();
    checks++; if (d !== e) begin errors++; $display("FAIL ferr_status: got %h required %h", d, e); end
    send_word(32'h1234_5678, 1'b0);
    bus_read(2'b01, 1'b1, d); e = model_pop();
    checks++; if (d !== e) begin errors++; $display("FAIL ferr_next_data: got %h required %h", d, e); end
    bus_write(2'b00, 32'h4); m_fe = 1'b0;
    bus_read(2'b00, 1'b0, d); e = exp_status();
    checks++; if (d !== e) begin errors++; $display("FAIL ferr_w1c: got %h required %h", d, e); end
  endtask

  task automatic test_fifo_fill();
    logic [31:0] d, e;
    bus_write(2'b10, 32'h1);
    for (int k = 0; k < 5; k++) send_word($urandom, 1'b0);
    bus_read(2'b00, 1'b0, d); e = exp_status();
    checks++; if (d !== e) begin errors++; $display("FAIL fill_status: got %h required %h", d, e); end
    for (int k = 0; k < CAP + 1; k++) begin
      bus_read(2'b01, 1'b1, d); e = model_pop();
      checks++; if (d !== e) begin errors++; $display("FAIL fill_data%0d: got %h required %h", k, d, e); end
    end
    bus_write(2'b00, 32'h2); m_ov = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, e, w1, w2;
    w1 = $urandom; w2 = $urandom;
    bus_write(2'b10, 32'h5);
    ss_low();
    send_bits(w1, 32, 1'b0);
    send_bits(w2, 32, 1'b0);
    ss_high();
    model_frame(w1); model_frame(w2);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL b2b_irq_set: got %b required 1", irq); end
    bus_read(2'b00, 1'b0, d); e = exp_status();
    checks++; if (d !== e) begin errors++; $display("FAIL b2b_status: got %h required %h", d, e); end
    for (int k = 0; k < 3; k++) begin
      bus_read(2'b01, 1'b1, d); e = model_pop();
      checks++; if (d !== e) begin errors++; $display("FAIL b2b_data%0d: got %h required %h", k, d, e); end
    end
    tick(2);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL b2b_irq_clr: got %b required 0", irq); end
    bus_write(2'b00, 32'h2); m_ov = 1'b0;
  endtask

  task automatic test_disable_mid_frame();
    logic [31:0] d, e;
    bus_write(2'b10, 32'h1);
    ss_low();
    send_bits($urandom, 10, 1'b0);
    bus_write(2'b10, 32'h0);
    send_bits($urandom, 22, 1'b0);
    ss_high();
    bus_read(2'b00, 1'b0, d); e = exp_status();
    checks++; if (d !== e) begin errors++; $display("FAIL dis_status: got %h required %h", d, e); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d, e;
    bus_write(2'b10, 32'h1);
    ss_low();
    send_bits($urandom, 20, 1'b0);
    bus_read(2'b00, 1'b0, d); e = exp_status() | 32'h2;
    checks++; if (d !== e) begin errors++; $display("FAIL rstmid_busy: got %h required %h", d, e); end
    rst = 1'b1; tick(2); rst = 1'b0; tick(1);
    mq.delete(); m_ov = 1'b0; m_fe = 1'b0;
    bus_read(2'b00, 1'b0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rstmid_status: got %h required %h", d, 32'h0); end
    bus_read(2'b10, 1'b0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rstmid_cfg: got %h required %h", d, 32'h0); end
    ss_n_in = 1'b1; tick(SYNC + 4);
    bus_write(2'b10, 32'h1);
    send_word(32'hFFFF_0000, 1'b0);
    bus_read(2'b00, 1'b0, d); e = exp_status();
    checks++; if (d !== e) begin errors++; $display("FAIL rstmid_next_status: got %h required %h", d, e); end
    bus_read(2'b01, 1'b1, d); e = model_pop();
    checks++; if (d !== e) begin errors++; $display("FAIL rstmid_next_data: got %h required %h", d, e); end
  endtask

  initial begin
    rst = 1'b1; data_in = 32'h0; addr = 2'b00; we = 1'b0; rd_en = 1'b0; cs_n = 1'b1;
    sclk_in = 1'b0; ss_n_in = 1'b1; mosi_in = 1'b0;
    m_ov = 1'b0; m_fe = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    test_reset();
    test_rising();
    test_falling();
    test_overrun();
    test_frame_err();
    test_fifo_fill();
    test_back_to_back();
    test_disable_mid_frame();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
